controlador_carga: RTL and testbench
====================================

// Module: controlador_carga
// PURPOSE
//  Boot-time program loader: copies a program word-by-word from a slow source store (disk/ROM
//  port) into instruction memory, stopping after the HALT word (opcode [31:26]=6'b111111).
//  Writer side of the BIOS->memory hand-off: it fills the memory that the instruction-fetch
//  selector switches to after BIOS HALT. Single clock domain, sits between storage and imem.
// PARAMETERS
//  ADDR_W     32    width of source and destination word addresses
//  MAX_WORDS  1024  max words copied before HALT is declared missing (error)
//  TIMEOUT    255   max cycles to wait for src_valid after a src_rd pulse
// PORTS
//  clk        in   1       rising-edge clock
//  reset_n    in   1       asynchronous, active-low reset
//  start      in   1       1-cycle pulse: begin load (ignored while busy)
//  src_base   in   ADDR_W  first source word address (sampled on accepted start)
//  dst_base   in   ADDR_W  first imem word address (sampled on accepted start)
//  src_rd     out  1       1-cycle read request to source
//  src_addr   out  ADDR_W  source address, valid while waiting for src_valid
//  src_rdata  in   32      source data, valid when src_valid=1
//  src_valid  in   1       source data strobe, >=1 cycle after src_rd
//  mem_we     out  1       1-cycle imem write strobe
//  mem_addr   out  ADDR_W  imem write address
//  mem_wdata  out  32      imem write data
//  busy       out  1       high from accepted start until done/error
//  done       out  1       1-cycle pulse after HALT word written
//  error      out  1       sticky: overflow or timeout; cleared by next accepted start
//  count      out  16      words written in current/last load (held after finish)
//  checksum   out  32      see CONFIGURATION
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; src_rd, mem_we, busy, done, error=0; count=0;
//   addresses/data=0; checksum=0. Takes effect mid-transfer; partially written imem untouched.
//  FSM: IDLE -> REQ -> WAIT -> WRITE -> (REQ | FIN | ERR); FIN -> IDLE; ERR -> IDLE.
//  IDLE: start=1 -> latch bases, count=0, error=0, checksum=0, busy=1 -> REQ.
//   src_valid in IDLE ignored (stale data never written).
//  REQ: src_rd=1 for exactly one cycle, src_addr=src_base+count -> WAIT; timer cleared.
//  WAIT: src_valid=1 -> capture src_rdata -> WRITE. Timer increments each cycle without
//   src_valid; on reaching TIMEOUT -> ERR. src_valid in same cycle as timeout wins (no error).
//  WRITE: mem_we=1 one cycle, mem_addr=dst_base+count, mem_wdata=captured word; count+1.
//   If word[31:26]==6'b111111 -> FIN (HALT word is itself written).
//   Else if count+1==MAX_WORDS -> ERR. Else -> REQ.
//  Throughput: 3 cycles/word with 1-cycle source latency (REQ, WAIT, WRITE).
//  FIN: done=1 one cycle, busy=0 -> IDLE. ERR: error=1 (sticky), busy=0 -> IDLE; no done.
//  Address arithmetic modulo 2^ADDR_W (wraps silently). start while busy ignored.
//  mem_addr/mem_wdata hold last written values when mem_we=0.
// CONFIGURATION
//  CONTROLADOR_CARGA_CHECKSUM_EN defined: checksum = mod-2^32 sum of every word written
//   (HALT word included), updated on each mem_we, cleared on accepted start, held afterwards.
//  Not defined: checksum tied to 32'h0, no adder logic.
// TESTING
//  3-word program {32'h20010005, 32'h20020003, 32'hFC000000}, src latency 1, bases 0x10/0x0
//   -> mem writes 0x0,0x1,0x2 in order; done pulse cycle 10 after start; count=3; error=0.
//  Source latency 5 cycles on word 2 -> src_rd pulses once per word; same imem contents.
//  No HALT, MAX_WORDS=4 -> exactly 4 writes, error=1, no done, busy falls same cycle.
//  src_valid withheld after src_rd -> error=1 after TIMEOUT cycles; no write; next start
//   clears error and load completes.
//  reset_n low mid-WAIT -> all outputs 0 immediately; later src_valid ignored; start restarts.
//  CHECKSUM_EN on, first test -> checksum = 32'h20010005+32'h20020003+32'hFC000000
//   = 32'h3C030008; off -> checksum=0.

Source files
------------

// File: rtl/controlador_carga.sv
`default_nettype none
// ============================================================================
//  Module   : controlador_carga
//  Purpose  : Boot-time program loader. Copies a program word by word from a
//             slow source store into instruction memory. It stops after the
//             HALT word (opcode [31:26] == 6'b111111), which is itself
//             written. Detects a missing HALT (MAX_WORDS reached) and a source
//             that never answers (TIMEOUT).
//  Ports    : clk, reset_n (async, active low)
//             start, src_base, dst_base   - load request and base addresses
//             src_rd, src_addr            - one-cycle source read request
//             src_rdata, src_valid        - source data return
//             mem_we, mem_addr, mem_wdata - imem write port
//             busy, done, error, count    - load status
//             checksum                    - running sum of written words
//  Options  : CONTROLADOR_CARGA_CHECKSUM_EN enables the checksum adder.
//             Without it, checksum is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module controlador_carga #(
    parameter int ADDR_W    = 32,
    parameter int MAX_WORDS = 1024,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              src_rd,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [31:0]       src_rdata,
    input  logic              src_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       count,
    output logic [31:0]       checksum
);

    localparam int         c_tmr_w    = $clog2(TIMEOUT + 1);
    localparam logic [5:0] c_halt_op  = 6'b111111;
    // The timer counts WAIT cycles already spent without data. The
    // TIMEOUT-th empty cycle is the last one allowed.
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT - 1);
    localparam logic [16:0]        c_max      = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_FIN   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_base_q, src_base_d;
    logic [ADDR_W-1:0]   dst_base_q, dst_base_d;
    logic [15:0]         count_q, count_d;
    logic [c_tmr_w-1:0]  timer_q, timer_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                error_q, error_d;
    logic                start_acc;

    assign start_acc = (state_q == S_IDLE) && start;

    always_comb begin
        state_d     = state_q;
        src_base_d  = src_base_q;
        dst_base_d  = dst_base_q;
        count_d     = count_q;
        timer_d     = timer_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        error_d     = error_q;
        src_rd      = 1'b0;
        mem_we      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // src_valid is deliberately not looked at here: a late
                // answer to an aborted request must never reach imem.
                if (start_acc) begin
                    src_base_d = src_base;
                    dst_base_d = dst_base;
                    count_d    = '0;
                    error_d    = 1'b0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                busy    = 1'b1;
                src_rd  = 1'b1;
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                // Data arriving on the last allowed cycle still wins.
                if (src_valid) begin
                    mem_wdata_d = src_rdata;
                    mem_addr_d  = dst_base_q + ADDR_W'(count_q);
                    state_d     = S_WRITE;
                end else if (timer_q == c_tmr_last) begin
                    error_d = 1'b1;
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WRITE: begin
                busy    = 1'b1;
                mem_we  = 1'b1;
                count_d = count_q + 16'd1;
                if (mem_wdata_q[31:26] == c_halt_op) begin
                    state_d = S_FIN;
                end else if (({1'b0, count_q} + 17'd1) == c_max) begin
                    error_d = 1'b1;
                    state_d = S_ERR;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            src_base_q  <= '0;
            dst_base_q  <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_base_q  <= src_base_d;
            dst_base_q  <= dst_base_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            error_q     <= error_d;
        end
    end

    assign src_addr  = src_base_q + ADDR_W'(count_q);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign error     = error_q;
    assign count     = count_q;

`ifdef CONTROLADOR_CARGA_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (start_acc) begin
            checksum_d = '0;
        end else if (mem_we) begin
            checksum_d = checksum_q + mem_wdata_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_controlador_carga.sv
`default_nettype none
// ============================================================================
//  Module   : tb_controlador_carga
//  Purpose  : Self-checking bench for controlador_carga. For each load, a
//             behavioural model turns the program, the bases and the
//             per-word source latencies into an expected cycle-by-cycle
//             timeline. One compare process checks every DUT output against
//             that timeline on the falling edge. A few literal values pin
//             the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_controlador_carga;

    localparam int MAXW = 4;
    localparam int TO   = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] src_base, dst_base;
    logic        src_rd;
    logic [31:0] src_addr;
    logic [31:0] src_rdata;
    logic        src_valid;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        busy, done, error;
    logic [15:0] count;
    logic [31:0] checksum;

    always #5 clk = ~clk;

    controlador_carga #(.ADDR_W(32), .MAX_WORDS(MAXW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .src_base(src_base), .dst_base(dst_base),
        .src_rd(src_rd), .src_addr(src_addr),
        .src_rdata(src_rdata), .src_valid(src_valid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error),
        .count(count), .checksum(checksum)
    );

    // One cycle of expected behaviour: the inputs to drive and the outputs required
    typedef struct {
        bit          start;
        logic [31:0] sb, db;
        bit          vld;
        logic [31:0] vdata;
        bit          rd, chk_sa, we, bsy, dn, err;
        logic [31:0] sa, wa, wd, cks;
        logic [15:0] cnt;
    } cyc_t;

    cyc_t        sched[$];
    cyc_t        e;
    bit          chk_en = 1'b0;
    int          total = 0, bad = 0;
    int          cyc = 0, start_at = 0, done_at = -1;
    int          nwrites = 0, ndone = 0, nrd = 0;
    logic [31:0] cap [logic [31:0]];

    // Model state: the values the DUT holds between loads
    logic [31:0] m_wa = 0, m_wd = 0, m_cks = 0;
    int          m_cnt = 0;
    bit          m_err = 1'b0;

    logic [31:0] prog [MAXW];
    int          lat  [MAXW];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] cks_exp(input logic [31:0] v);
`ifdef CONTROLADOR_CARGA_CHECKSUM_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    function automatic logic [31:0] capv(input logic [31:0] a);
        return cap.exists(a) ? cap[a] : 32'hDEADBEEF;
    endfunction

    function automatic cyc_t idle_entry();
        cyc_t c;
        c.start = 1'b0; c.sb = $urandom; c.db = $urandom;
        c.vld = 1'b0; c.vdata = $urandom;
        c.rd = 1'b0; c.chk_sa = 1'b0; c.we = 1'b0; c.bsy = 1'b0; c.dn = 1'b0;
        c.err = m_err; c.sa = 32'h0; c.wa = m_wa; c.wd = m_wd;
        c.cks = m_cks; c.cnt = 16'(m_cnt);
        return c;
    endfunction

    function automatic cyc_t busy_entry(input bit busy_starts);
        cyc_t c;
        c = idle_entry();
        c.bsy = 1'b1;
        c.start = busy_starts && ($urandom_range(0, 5) == 0);
        return c;
    endfunction

    // Expected timeline of one load: word i takes one request cycle, lat[i]
    // wait cycles and one write cycle. A latency above TO ends the load
    // after TO empty wait cycles.
    task automatic build(input logic [31:0] sb, input logic [31:0] db, input bit busy_starts);
        cyc_t c;
        int   late_idx;
        late_idx = -1;
        sched.delete();
        c = idle_entry(); c.start = 1'b1; c.sb = sb; c.db = db;
        sched.push_back(c);
        m_err = 1'b0; m_cnt = 0; m_cks = 32'h0;
        for (int i = 0; i < MAXW; i++) begin
            int req_idx;
            c = busy_entry(busy_starts); c.rd = 1'b1; c.chk_sa = 1'b1; c.sa = sb + i;
            req_idx = sched.size();
            sched.push_back(c);
            if (lat[i] <= TO) begin
                for (int k = 1; k <= lat[i]; k++) begin
                    c = busy_entry(busy_starts); c.chk_sa = 1'b1; c.sa = sb + i;
                    if (k == lat[i]) begin c.vld = 1'b1; c.vdata = prog[i]; end
                    sched.push_back(c);
                end
                m_wa = db + i; m_wd = prog[i];
                c = busy_entry(busy_starts); c.we = 1'b1;
                sched.push_back(c);
                m_cnt++; m_cks += prog[i];
                if (prog[i][31:26] == 6'h3F) begin
                    c = idle_entry(); c.dn = 1'b1; sched.push_back(c);
                    break;
                end
                if (i + 1 == MAXW) begin
                    m_err = 1'b1; sched.push_back(idle_entry());
                    break;
                end
            end else begin
                for (int k = 1; k <= TO; k++) begin
                    c = busy_entry(busy_starts); c.chk_sa = 1'b1; c.sa = sb + i;
                    sched.push_back(c);
                end
                m_err = 1'b1; sched.push_back(idle_entry());
                late_idx = req_idx + lat[i];
                break;
            end
        end
        // Idle tail with stray strobes that must be ignored
        for (int g = 0; g < 4; g++) begin
            c = idle_entry(); c.vld = (g < 3) && ($urandom_range(0, 1) == 1);
            sched.push_back(c);
        end
        if (late_idx >= 0 && late_idx < sched.size() - 1) begin
            sched[late_idx].vld = 1'b1;
        end
    endtask

    task automatic exec(input int upto);
        for (int k = 0; k < sched.size() && k < upto; k++) begin
            @(posedge clk); #1;
            e         = sched[k];
            start     = e.start;
            src_base  = e.sb;
            dst_base  = e.db;
            src_valid = e.vld;
            src_rdata = e.vdata;
            if (k == 0) start_at = cyc;
            chk_en = 1'b1;
        end
    endtask

    task automatic clear_stats();
        nwrites = 0; ndone = 0; nrd = 0; done_at = -1;
        cap.delete();
    endtask

    task automatic set_prog1(input int l1);
        prog[0] = 32'h20010005; prog[1] = 32'h20020003;
        prog[2] = 32'hFC000000; prog[3] = 32'h00000000;
        lat[0] = 1; lat[1] = l1; lat[2] = 1; lat[3] = 1;
    endtask

    // Single compare process
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin cap[mem_addr] = mem_wdata; nwrites++; end
        if (done === 1'b1) begin ndone++; done_at = cyc; end
        if (src_rd === 1'b1) nrd++;
        if (chk_en) begin
            check("src_rd",    32'(src_rd), 32'(e.rd));
            check("mem_we",    32'(mem_we), 32'(e.we));
            check("busy",      32'(busy),   32'(e.bsy));
            check("done",      32'(done),   32'(e.dn));
            check("error",     32'(error),  32'(e.err));
            check("count",     32'(count),  32'(e.cnt));
            check("mem_addr",  mem_addr,    e.wa);
            check("mem_wdata", mem_wdata,   e.wd);
            check("checksum",  checksum,    cks_exp(e.cks));
            if (e.chk_sa) check("src_addr", src_addr, e.sa);
        end
    end

    initial begin
        logic [31:0] sbv, dbv;
        reset_n = 1'b0; start = 1'b0; src_valid = 1'b0; src_rdata = 32'h0;
        src_base = 32'h0; dst_base = 32'h0;
        @(posedge clk); #1;
        e = idle_entry(); e.chk_sa = 1'b1; e.sa = 32'h0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reference program, 1-cycle source latency
        set_prog1(1); clear_stats();
        build(32'h10, 32'h0, 1'b0); exec(1 << 30);
        check("t1_done_latency", 32'(done_at - start_at), 32'd10);
        check("t1_writes", 32'(nwrites), 32'd3);
        check("t1_imem0", capv(32'h0), 32'h20010005);
        check("t1_imem1", capv(32'h1), 32'h20020003);
        check("t1_imem2", capv(32'h2), 32'hFC000000);
        check("t1_count", 32'(count), 32'd3);
        check("t1_error", 32'(error), 32'd0);
`ifdef CONTROLADOR_CARGA_CHECKSUM_EN
        check("t1_checksum", checksum, 32'h3C030008);
`else
        check("t1_checksum", checksum, 32'h0);
`endif

        // 5-cycle latency on word 2
        set_prog1(5); clear_stats();
        build(32'h10, 32'h0, 1'b1); exec(1 << 30);
        check("t2_rd_pulses", 32'(nrd), 32'd3);
        check("t2_imem1", capv(32'h1), 32'h20020003);
        check("t2_done", 32'(ndone), 32'd1);

        // No HALT: overflow after MAX_WORDS writes
        for (int i = 0; i < MAXW; i++) begin prog[i] = 32'h1000_0000 + i; lat[i] = 1; end
        clear_stats();
        build(32'h100, 32'h200, 1'b0); exec(1 << 30);
        check("t3_writes", 32'(nwrites), 32'(MAXW));
        check("t3_done", 32'(ndone), 32'd0);
        check("t3_error", 32'(error), 32'd1);
        check("t3_imem_last", capv(32'h203), 32'h1000_0003);

        // Source never answers: timeout, no write; then a clean load
        set_prog1(1); lat[0] = TO + 1; clear_stats();
        build(32'h10, 32'h40, 1'b0); exec(1 << 30);
        check("t4_writes", 32'(nwrites), 32'd0);
        check("t4_error", 32'(error), 32'd1);
        set_prog1(1); lat[0] = TO; clear_stats();
        build(32'h10, 32'h40, 1'b0); exec(1 << 30);
        check("t4_recover_error", 32'(error), 32'd0);
        check("t4_recover_done", 32'(ndone), 32'd1);

        // Reset while waiting for source data
        set_prog1(1); lat[0] = 5; clear_stats();
        build(32'h10, 32'h80, 1'b0); exec(3);
        @(posedge clk); #1;
        reset_n = 1'b0; start = 1'b0; src_valid = 1'b0;
        m_wa = 0; m_wd = 0; m_cks = 0; m_cnt = 0; m_err = 1'b0;
        e = idle_entry(); e.chk_sa = 1'b1; e.sa = 32'h0;
        @(posedge clk); #1; src_valid = 1'b1; src_rdata = 32'h12345678;
        @(posedge clk); #1; reset_n = 1'b1;
        @(posedge clk); #1; src_valid = 1'b0;
        check("t5_no_write", 32'(nwrites), 32'd0);
        set_prog1(1); clear_stats();
        build(32'h10, 32'h80, 1'b0); exec(1 << 30);
        check("t5_restart_imem2", capv(32'h82), 32'hFC000000);

        // Randomized loads
        for (int n = 0; n < 30; n++) begin
            int h, r;
            sbv = (n % 6 == 0) ? 32'hFFFF_FFFE : $urandom;
            dbv = (n % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
            h = $urandom_range(0, MAXW);
            for (int i = 0; i < MAXW; i++) begin
                prog[i] = $urandom;
                if (prog[i][31:26] == 6'h3F) prog[i][31] = 1'b0;
                if (i == h) prog[i][31:26] = 6'h3F;
                r = $urandom_range(0, 15);
                lat[i] = (r == 0) ? TO : (r == 1) ? TO + int'($urandom_range(1, 3))
                                                  : int'($urandom_range(1, 3));
            end
            build(sbv, dbv, 1'b1); exec(1 << 30);
        end

        @(posedge clk); #1 chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
